// File: rtl/bubble_round_ctrl.sv
// Round sequencer for the bubble game: arbitrates fall ticks against joystick
// shots, drives the bubble manager and tracks score and level.
module bubble_round_ctrl #(
  parameter int unsigned TICK_BASE      = 32'd50000000,
  parameter int unsigned TICK_STEP      = 32'd5000000,
  parameter int unsigned TICK_MIN       = 32'd10000000,
  parameter int unsigned POPS_PER_LEVEL = 32'd8,
  parameter int unsigned LEVEL_W        = 32'd3,
  parameter int unsigned SCORE_W        = 32'd14,
  parameter int unsigned POP_TIMEOUT    = 32'd16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_btn,
  input  logic               shoot_req,
  input  logic [2:0]         shoot_pos,
  input  logic               bubble_full,
  input  logic               pop_done,
  input  logic [3:0]         pop_count,
  output logic               mgr_en,
  output logic               fall_tick,
  output logic               pop_req,
  output logic [2:0]         pop_pos,
  output logic [1:0]         state,
  output logic [LEVEL_W-1:0] level,
  output logic [SCORE_W-1:0] score,
  output logic               game_over
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_POP  = 2'd2,
    ST_OVER = 2'd3
  } state_t;

  localparam int unsigned CNT_W = $clog2(TICK_BASE + 32'd1);
  localparam int unsigned TO_W  = $clog2(POP_TIMEOUT + 32'd1);
  localparam int unsigned ACC_W = 32'd16;

  localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(32'd1);
  localparam logic [TO_W-1:0]    TO_ONE    = TO_W'(32'd1);
  localparam logic [TO_W-1:0]    TO_LAST   = TO_W'(POP_TIMEOUT - 32'd1);
  localparam logic [ACC_W-1:0]   ACC_STEP  = ACC_W'(POPS_PER_LEVEL);
  localparam logic [LEVEL_W-1:0] LEVEL_ONE = LEVEL_W'(32'd1);
  localparam logic [LEVEL_W-1:0] LEVEL_MAX = {LEVEL_W{1'b1}};
  localparam logic [SCORE_W-1:0] SCORE_MAX = {SCORE_W{1'b1}};

  // Last counter value of a fall period at the given level (period minus one).
  function automatic logic [CNT_W-1:0] tick_limit(input logic [LEVEL_W-1:0] lvl);
    logic [31:0] drop_v;
    logic [31:0] period_v;
    drop_v = 32'(lvl) * TICK_STEP;
    if (drop_v + TICK_MIN >= TICK_BASE) begin
      period_v = TICK_MIN;
    end else begin
      period_v = TICK_BASE - drop_v;
    end
    return CNT_W'(period_v - 32'd1);
  endfunction

  state_t             state_r;
  logic [CNT_W-1:0]   cnt_r;
  logic [CNT_W-1:0]   lim_r;
  logic [TO_W-1:0]    to_cnt_r;
  logic [ACC_W-1:0]   acc_r;
  logic               pend_r;
  logic [2:0]         pend_pos_r;
  logic               mgr_en_r;
  logic               fall_tick_r;
  logic               pop_req_r;
  logic [2:0]         pop_pos_r;
  logic [LEVEL_W-1:0] level_r;
  logic [SCORE_W-1:0] score_r;
  logic               game_over_r;

  logic               tick_due_s;
  logic [SCORE_W:0]   score_sum_s;
  logic [SCORE_W-1:0] score_next_s;
  logic [ACC_W-1:0]   acc_sum_s;
  logic [ACC_W-1:0]   acc_next_s;
  logic [LEVEL_W-1:0] level_next_s;

  // Tick detection and the score/level/accumulator update applied on pop_done.
  always_comb begin
    tick_due_s   = (cnt_r == lim_r);
    score_sum_s  = {1'b0, score_r} + {{(SCORE_W-3){1'b0}}, pop_count};
    acc_sum_s    = acc_r + {{(ACC_W-4){1'b0}}, pop_count};
    score_next_s = score_r;
    acc_next_s   = acc_sum_s;
    level_next_s = level_r;
    if (score_sum_s[SCORE_W]) begin
      score_next_s = SCORE_MAX;
    end else begin
      score_next_s = score_sum_s[SCORE_W-1:0];
    end
    if (acc_sum_s >= ACC_STEP) begin
      acc_next_s = acc_sum_s - ACC_STEP;
      if (level_r == LEVEL_MAX) begin
        level_next_s = level_r;
      end else begin
        level_next_s = level_r + LEVEL_ONE;
      end
    end else begin
      acc_next_s   = acc_sum_s;
      level_next_s = level_r;
    end
  end

  // Round FSM with all outputs registered alongside the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      cnt_r       <= '0;
      lim_r       <= '0;
      to_cnt_r    <= '0;
      acc_r       <= '0;
      pend_r      <= 1'b0;
      pend_pos_r  <= 3'd0;
      mgr_en_r    <= 1'b0;
      fall_tick_r <= 1'b0;
      pop_req_r   <= 1'b0;
      pop_pos_r   <= 3'd0;
      level_r     <= '0;
      score_r     <= '0;
      game_over_r <= 1'b0;
    end else begin
      fall_tick_r <= 1'b0;
      pop_req_r   <= 1'b0;
      case (state_r)
        ST_IDLE, ST_OVER: begin
          if (start_btn) begin
            state_r     <= ST_PLAY;
            score_r     <= '0;
            level_r     <= '0;
            acc_r       <= '0;
            cnt_r       <= '0;
            lim_r       <= tick_limit('0);
            pend_r      <= 1'b0;
            mgr_en_r    <= 1'b1;
            game_over_r <= 1'b0;
          end
        end
        ST_PLAY: begin
          if (bubble_full) begin
            state_r     <= ST_OVER;
            pend_r      <= 1'b0;
            mgr_en_r    <= 1'b0;
            game_over_r <= 1'b1;
          end else if (tick_due_s) begin
            // A shot colliding with the tick is parked and issued next cycle.
            fall_tick_r <= 1'b1;
            cnt_r       <= '0;
            lim_r       <= tick_limit(level_r);
            if (shoot_req) begin
              pend_r     <= 1'b1;
              pend_pos_r <= shoot_pos;
            end
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
            if (shoot_req || pend_r) begin
              pop_pos_r <= shoot_req ? shoot_pos : pend_pos_r;
              pop_req_r <= 1'b1;
              pend_r    <= 1'b0;
              to_cnt_r  <= '0;
              state_r   <= ST_POP;
            end
          end
        end
        ST_POP: begin
          if (pop_done) begin
            score_r <= score_next_s;
            acc_r   <= acc_next_s;
            level_r <= level_next_s;
            state_r <= ST_PLAY;
          end else if (to_cnt_r == TO_LAST) begin
            state_r <= ST_PLAY;
          end else begin
            to_cnt_r <= to_cnt_r + TO_ONE;
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          mgr_en_r    <= 1'b0;
          game_over_r <= 1'b0;
        end
      endcase
    end
  end

  assign mgr_en    = mgr_en_r;
  assign fall_tick = fall_tick_r;
  assign pop_req   = pop_req_r;
  assign pop_pos   = pop_pos_r;
  assign state     = state_r;
  assign level     = level_r;
  assign score     = score_r;
  assign game_over = game_over_r;

endmodule
